// File: rtl/sw_input_unpacker.sv
// Parses software byte-channel packets (4-byte header + payload) and repacks the
// payload into DATA_WIDTH-wide FrameLink frames on the channel named in the header.
module sw_input_unpacker #(
   parameter int DATA_WIDTH = 64,
   parameter int CHANNELS   = 2,
   localparam int BYTES     = DATA_WIDTH / 8,
   localparam int REM_W     = (BYTES > 1) ? $clog2(BYTES) : 1
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [7:0]            IN_DATA,
   input  logic                  IN_VALID,
   output logic                  IN_READY,
   output logic [DATA_WIDTH-1:0] TX_DATA,
   output logic [REM_W-1:0]      TX_REM,
   output logic                  TX_SOF_N,
   output logic                  TX_EOF_N,
   output logic [CHANNELS-1:0]   TX_SRC_RDY_N,
   input  logic [CHANNELS-1:0]   TX_DST_RDY_N,
   output logic                  ERR_DROP,
   output logic [31:0]           DROP_CNT
);

   typedef enum logic [2:0] {
      HDR0, HDR1, HDR2, HDR3, COLLECT, EMIT, DISCARD
   } state_t;

   state_t                state;
   logic [7:0]            id_q;
   logic [7:0]            type_q;
   logic [7:0]            len_lo_q;
   logic [15:0]           remain_q;
   logic [REM_W-1:0]      lane_q;
   logic [DATA_WIDTH-1:0] word_q;
   logic                  first_q;
   logic                  last_q;

   logic                  accept;
   logic [15:0]           hdr_len;
   logic                  bad_hdr;
   logic                  last_byte;
   logic                  lane_full;
   logic                  dst_ok;
   logic [CHANNELS-1:0]   ch_mask;
   logic [DATA_WIDTH-1:0] word_next;

   assign IN_READY  = !RESET && (state != EMIT);
   assign accept    = IN_VALID && IN_READY;
   assign hdr_len   = {IN_DATA, len_lo_q};
   assign bad_hdr   = (id_q >= 8'(CHANNELS)) || (type_q != 8'h00);
   assign last_byte = (remain_q == 16'd1);
   assign lane_full = (lane_q == REM_W'(BYTES - 1));
   assign dst_ok    = |(ch_mask & ~TX_DST_RDY_N);

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      ch_mask = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         ch_mask[c] = (id_q == 8'(c));
      end
      word_next = word_q;
      word_next[{lane_q, 3'b000} +: 8] = IN_DATA;
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers
   // see pre-edge values regardless of statement order.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state        <= HDR0;
         id_q         <= '0;
         type_q       <= '0;
         len_lo_q     <= '0;
         remain_q     <= '0;
         lane_q       <= '0;
         word_q       <= '0;
         first_q      <= 1'b0;
         last_q       <= 1'b0;
         TX_DATA      <= '0;
         TX_REM       <= '0;
         TX_SOF_N     <= 1'b1;
         TX_EOF_N     <= 1'b1;
         TX_SRC_RDY_N <= '1;
         ERR_DROP     <= 1'b0;
         DROP_CNT     <= '0;
      end else begin
         ERR_DROP <= 1'b0;
         unique case (state)
            HDR0: if (accept) begin
               id_q  <= IN_DATA;
               state <= HDR1;
            end
            HDR1: if (accept) begin
               type_q <= IN_DATA;
               state  <= HDR2;
            end
            HDR2: if (accept) begin
               len_lo_q <= IN_DATA;
               state    <= HDR3;
            end
            HDR3: if (accept) begin
               remain_q <= hdr_len;
               if (bad_hdr) begin
                  ERR_DROP <= 1'b1;
                  if (DROP_CNT != '1) DROP_CNT <= DROP_CNT + 32'd1;
                  state <= (hdr_len != 16'd0) ? DISCARD : HDR0;
               end else if (hdr_len == 16'd0) begin
                  state <= HDR0;
               end else begin
                  lane_q  <= '0;
                  word_q  <= '0;
                  first_q <= 1'b1;
                  state   <= COLLECT;
               end
            end
            COLLECT: if (accept) begin
               remain_q <= remain_q - 16'd1;
               if (lane_full || last_byte) begin
                  // Lane index of the closing byte is exactly the REM of this word.
                  TX_DATA      <= word_next;
                  TX_REM       <= lane_q;
                  TX_SOF_N     <= ~first_q;
                  TX_EOF_N     <= ~last_byte;
                  TX_SRC_RDY_N <= ~ch_mask;
                  last_q       <= last_byte;
                  state        <= EMIT;
               end else begin
                  word_q <= word_next;
                  lane_q <= lane_q + REM_W'(1);
               end
            end
            EMIT: if (dst_ok) begin
               TX_SRC_RDY_N <= '1;
               TX_SOF_N     <= 1'b1;
               TX_EOF_N     <= 1'b1;
               first_q      <= 1'b0;
               lane_q       <= '0;
               word_q       <= '0;
               state        <= last_q ? HDR0 : COLLECT;
            end
            DISCARD: if (accept) begin
               remain_q <= remain_q - 16'd1;
               if (last_byte) state <= HDR0;
            end
            default: state <= HDR0;
         endcase
      end
   end

endmodule

// File: doc/sw_input_unpacker.md
Name: sw_input_unpacker

Overview:
Hardware-side counterpart of the software byte-transfer channel in the HW/SW verification framework. It takes the byte stream of software packets, parses a 4-byte header, and repacks the payload into DATA_WIDTH-wide FrameLink frames. Each frame goes to one of CHANNELS output channels, selected by the header. Packets that are malformed or addressed to a non-existent channel are consumed and counted, never forwarded.

Parameters:
DATA_WIDTH, 64, output word width in bits; multiple of 8, range 8..512
CHANNELS, 2, number of FrameLink output channels, range 1..16
REM_W, log2(DATA_WIDTH/8) (minimum 1), derived width of TX_REM

Ports:
CLK  in  1  clock
RESET  in  1  synchronous, active-high reset
IN_DATA  in  8  packet byte from the software transfer channel
IN_VALID  in  1  IN_DATA is valid
IN_READY  out  1  block accepts a byte; a byte transfers when IN_VALID=1 and IN_READY=1
TX_DATA  out  DATA_WIDTH  output word, shared by all channels; first byte in bits 7:0
TX_REM  out  REM_W  index of the last valid byte in the word
TX_SOF_N  out  1  start of frame, active low
TX_EOF_N  out  1  end of frame, active low
TX_SRC_RDY_N  out  CHANNELS  per-channel source ready, active low; at most one bit is 0 at a time
TX_DST_RDY_N  in  CHANNELS  per-channel destination ready, active low
ERR_DROP  out  1  one-cycle pulse when a packet is discarded
DROP_CNT  out  32  count of discarded packets; saturates at 0xFFFFFFFF

Behaviour:
- Clock and reset: single clock CLK. RESET is synchronous and active-high.
- Packet format: byte0 = channel id; byte1 = type (must be 0x00); bytes 2..3 = payload length L in bytes, little-endian (byte2 = LSB); then L payload bytes.
- States: HDR0, HDR1, HDR2, HDR3, COLLECT, EMIT, DISCARD.
  - HDR0..HDR3: each accepted byte advances one state; channel id, type and length are captured.
  - HDR3 exit:
    - id >= CHANNELS or type != 0: go to DISCARD if L > 0, else to HDR0. In both cases pulse ERR_DROP and increment DROP_CNT.
    - valid header with L = 0: return to HDR0, emit nothing, no error.
    - otherwise: go to COLLECT.
  - COLLECT: accepts one byte per cycle into byte lane k (0-based within the word); unused lanes read 0. After the last lane (k = DATA_WIDTH/8-1) or the last payload byte, go to EMIT.
  - EMIT:
    - Drive TX_SRC_RDY_N[ch]=0 and present TX_DATA, TX_REM, TX_SOF_N, TX_EOF_N; hold all of them stable until TX_DST_RDY_N[ch]=0.
    - On transfer: go to HDR0 if this was the last word, else to COLLECT.
    - TX_SOF_N=0 only on the first word of a frame; TX_EOF_N=0 only on the last word.
    - TX_REM = DATA_WIDTH/8-1 on full words, (L-1) mod (DATA_WIDTH/8) on the last word.
  - DISCARD: accepts and drops L bytes, then goes to HDR0.
- IN_READY: 1 in HDR0..HDR3, COLLECT and DISCARD; 0 in EMIT and while RESET=1.
- Throughput: 1 byte/cycle. EMIT costs at least one extra cycle per word; no bypass.
- Latency: the word is valid on the outputs in the cycle after its last byte is accepted.
- TX_DST_RDY_N of non-selected channels is ignored.
- Reset values: state HDR0; TX_SRC_RDY_N all 1; TX_SOF_N=1; TX_EOF_N=1; TX_DATA=0; TX_REM=0; ERR_DROP=0; DROP_CNT=0.
- Reset mid-operation: any partial frame is abandoned with no EOF emitted. The next packet's first word carries SOF.
- Simultaneous events: DROP_CNT at 0xFFFFFFFF stays there; ERR_DROP still pulses.
- Length arithmetic: a 16-bit down-counter of remaining bytes; maximum L = 65535. Last byte is detected when the counter equals 1.

Test Plan:
- DATA_WIDTH=32, CHANNELS=2. Packet 00 00 06 00 11 12 13 14 15 16 -> channel 0 emits two words:
  - 0x14131211 with SOF_N=0, EOF_N=1, REM=3;
  - then 0x00001615 with SOF_N=1, EOF_N=0, REM=1;
  - TX_SRC_RDY_N[1] stays 1 throughout.
- Packet 01 00 04 00 AA BB CC DD -> one word 0xDDCCBBAA on channel 1 with SOF_N=0, EOF_N=0, REM=3.
- Packet 05 00 03 00 01 02 03 -> all 7 bytes accepted with IN_READY=1; no TX_SRC_RDY_N asserted; ERR_DROP pulses once; DROP_CNT=1. Repeat with type 0x02 -> DROP_CNT=2.
- First packet with TX_DST_RDY_N[0]=1 held for 10 cycles on word 1 -> TX_DATA, TX_REM, SOF_N and EOF_N stable, IN_READY=0; after release both words arrive intact and none are duplicated.
- Packet 00 00 00 00 then 01 00 01 00 7E -> first packet produces no output; second gives 0x0000007E on channel 1 with SOF_N=0, EOF_N=0, REM=0.
- RESET for 1 cycle after the first word of a 12-byte frame -> all outputs return to reset values; the following packet's first word has SOF_N=0; DROP_CNT=0.
